// File: rtl/serial_addsub_32.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice reused over
// WIDTH/4 cycles, with a valid/ready handshake on both operand and result sides.

module serial_addsub_32_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] p, g;
    logic       c1, c2;

    assign p  = a ^ b;
    assign g  = a & b;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

module serial_addsub_32 #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = $clog2(NIB);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic [KW-1:0]    k_q;
    logic             cy_q, carry_q, cmsb_q, zero_q;

    logic [3:0] nib_a, nib_b, nib_s;
    logic       nib_c3, nib_c4;
    logic       last;

    assign nib_a = a_q[{k_q, 2'b00} +: 4];
    assign nib_b = b_q[{k_q, 2'b00} +: 4];
    assign last  = (k_q == KW'(NIB - 1));

    serial_addsub_32_cla4 u_slice (
        .a  (nib_a),
        .b  (nib_b),
        .ci (cy_q),
        .s  (nib_s),
        .c3 (nib_c3),
        .c4 (nib_c4)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    a_q   <= i_A;
                    b_q   <= i_sub ? ~i_B : i_B;
                    cy_q  <= i_sub;
                    k_q   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    res_q[{k_q, 2'b00} +: 4] <= nib_s;
                    cy_q <= nib_c4;
                    k_q  <= k_q + 1'b1;
                    if (last) begin
                        // Lower nibbles of res_q already hold this operation's sum.
                        carry_q <= nib_c4;
                        cmsb_q  <= nib_c3;
                        zero_q  <= (nib_s == 4'h0) && (res_q[WIDTH-5:0] == '0);
                        state   <= DONE;
                    end
                end
                DONE: if (i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready    = (state == IDLE);
    assign o_valid    = (state == DONE);
    assign o_result   = res_q;
    assign o_carry    = carry_q;
    assign o_overflow = cmsb_q ^ carry_q;
    assign o_zero     = zero_q;
endmodule

// File: tb/tb_serial_addsub_32.sv
// Directed and randomised checks of the nibble-serial adder/subtractor.

module tb_serial_addsub_32;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_A = '0;
    logic [31:0] i_B = '0;
    logic        i_sub = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_carry, o_overflow, o_zero;

    int checks = 0;
    int errors = 0;

    serial_addsub_32 #(.WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_A        (i_A),
        .i_B        (i_B),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_zero     (o_zero)
    );

    always #5 i_clk = ~i_clk;

    // Stimulus plumbing only; every comparison lives in the test tasks.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
        i_A = a; i_B = b; i_sub = sub; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!o_valid && lat < 30) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic release_done;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b want ready=1 valid=0", o_ready, o_valid);
        end
        checks++;
        if (o_result !== 32'h0 || o_carry !== 1'b0 || o_overflow !== 1'b0 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: res=%h c=%b v=%b z=%b want all 0", o_result, o_carry, o_overflow, o_zero);
        end
    endtask

    task automatic test_add_basic;
        int lat;
        start_op(32'h0000000C, 32'h0000000A, 1'b0);
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: ready=%b want 0", o_ready);
        end
        wait_done(lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL latency: got %0d want 8", lat);
        end
        checks++;
        if (o_result !== 32'h00000016 || o_carry !== 1'b0 || o_overflow !== 1'b0 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL add_basic: res=%h c=%b v=%b z=%b want 00000016 0 0 0", o_result, o_carry, o_overflow, o_zero);
        end
        release_done();
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: ready=%b valid=%b want 1 0", o_ready, o_valid);
        end
    endtask

    task automatic test_add_flags;
        int lat;
        start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 8 || o_result !== 32'h0 || o_carry !== 1'b1 || o_zero !== 1'b1 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: lat=%0d res=%h c=%b v=%b z=%b want 8 00000000 1 0 1", lat, o_result, o_carry, o_overflow, o_zero);
        end
        release_done();
        start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 8 || o_result !== 32'h80000000 || o_carry !== 1'b0 || o_zero !== 1'b0 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL add_ovf: lat=%0d res=%h c=%b v=%b z=%b want 8 80000000 0 1 0", lat, o_result, o_carry, o_overflow, o_zero);
        end
        release_done();
    endtask

    task automatic test_sub;
        int lat;
        start_op(32'h80000000, 32'h00000001, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 8 || o_result !== 32'h7FFFFFFF || o_carry !== 1'b1 || o_overflow !== 1'b1 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_ovf: lat=%0d res=%h c=%b v=%b z=%b want 8 7fffffff 1 1 0", lat, o_result, o_carry, o_overflow, o_zero);
        end
        release_done();
        start_op(32'd5, 32'd7, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 8 || o_result !== 32'hFFFFFFFE || o_carry !== 1'b0 || o_overflow !== 1'b0 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: lat=%0d res=%h c=%b v=%b z=%b want 8 fffffffe 0 0 0", lat, o_result, o_carry, o_overflow, o_zero);
        end
        release_done();
    endtask

    task automatic test_stall_and_ignore;
        int lat;
        logic [31:0] r0;
        logic [2:0]  f0;
        start_op(32'h12345678, 32'h11111111, 1'b0);
        repeat (3) begin @(posedge i_clk); #1; end
        // Fresh operands presented mid-operation must not disturb it.
        i_A = 32'hFFFFFFFF; i_B = 32'h00000003; i_sub = 1'b1; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wait_done(lat);
        checks++;
        if (lat !== 4 || o_result !== 32'h23456789 || o_carry !== 1'b0 || o_overflow !== 1'b0 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run: lat=%0d res=%h c=%b v=%b z=%b want 4 23456789 0 0 0", lat, o_result, o_carry, o_overflow, o_zero);
        end
        r0 = o_result;
        f0 = {o_carry, o_overflow, o_zero};
        i_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_result !== r0 || {o_carry, o_overflow, o_zero} !== f0) begin
                errors++;
                $display("FAIL stall%0d: valid=%b ready=%b res=%h flags=%b want 1 0 %h %b", i, o_valid, o_ready, o_result, {o_carry, o_overflow, o_zero}, r0, f0);
            end
        end
        i_valid = 1'b0;
        release_done();
    endtask

    task automatic test_reset_mid_run;
        int lat;
        start_op(32'h0F0F0F0F, 32'h01010101, 1'b0);
        repeat (3) begin @(posedge i_clk); #1; end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'h0 || o_carry !== 1'b0 || o_overflow !== 1'b0 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b res=%h c=%b v=%b z=%b want 1 0 0 0 0 0", o_ready, o_valid, o_result, o_carry, o_overflow, o_zero);
        end
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge i_clk); #1;
            if (o_valid) lat++;
        end
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL abort_valid: saw %0d valid cycles want 0", lat);
        end
        start_op(32'd1, 32'd1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 8 || o_result !== 32'h2 || o_carry !== 1'b0 || o_overflow !== 1'b0 || o_zero !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_add: lat=%0d res=%h want 8 00000002", lat, o_result);
        end
        release_done();
    endtask

    task automatic test_back_to_back;
        int first, second, ones;
        first = -1; second = -1; ones = 0;
        i_A = 32'd3; i_B = 32'd4; i_sub = 1'b0;
        i_valid = 1'b1; i_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge i_clk); #1;
            if (o_valid) begin
                ones++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        i_valid = 1'b0;
        checks++;
        if (first < 0 || second - first !== 10) begin
            errors++;
            $display("FAIL throughput: valid at %0d and %0d, want spacing 10", first, second);
        end
        checks++;
        if (ones !== 4) begin
            errors++;
            $display("FAIL pulse_count: got %0d valid cycles in 40 want 4", ones);
        end
        for (int c = 0; c < 30 && !o_ready; c++) begin @(posedge i_clk); #1; end
        i_ready = 1'b0;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain: ready=%b want 1", o_ready);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [31:0] a, b, eb, er;
        logic [32:0] full;
        logic sub, ec, ev, ez;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            if (n % 50 == 0) b = a;
            eb   = sub ? ~b : b;
            full = {1'b0, a} + {1'b0, eb} + {32'b0, sub};
            er   = full[31:0];
            ec   = full[32];
            ev   = sub ? ((a[31] != b[31]) && (er[31] != a[31]))
                       : ((a[31] == b[31]) && (er[31] != a[31]));
            ez   = (er == 32'h0);
            start_op(a, b, sub);
            wait_done(lat);
            checks++;
            if (lat !== 8 || o_result !== er) begin
                errors++;
                $display("FAIL rnd_res #%0d %h %s %h: lat=%0d res=%h want 8 %h", n, a, sub ? "-" : "+", b, lat, o_result, er);
            end
            checks++;
            if (o_carry !== ec) begin
                errors++;
                $display("FAIL rnd_carry #%0d: got %b want %b", n, o_carry, ec);
            end
            checks++;
            if (o_overflow !== ev) begin
                errors++;
                $display("FAIL rnd_ovf #%0d: got %b want %b", n, o_overflow, ev);
            end
            checks++;
            if (o_zero !== ez) begin
                errors++;
                $display("FAIL rnd_zero #%0d: got %b want %b", n, o_zero, ez);
            end
            release_done();
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_flags();
        test_sub();
        test_stall_and_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_addsub_32.md
SERIAL_ADDSUB_32 -- requirements
Module: serial_addsub_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; a legal value is a multiple of 4 and at least 8.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port o_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port i_A, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port i_B, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port i_sub, input, 1 bit: 0 selects A+B, 1 selects A-B.
REQ-009 The block SHALL have port o_valid, output, 1 bit: the result and flags are valid.
REQ-010 The block SHALL have port i_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port o_result, output, WIDTH bits: the sum or difference.
REQ-012 The block SHALL have port o_carry, output, 1 bit: carry out of the MSB; for subtract, 1 means no borrow.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: two's-complement signed overflow.
REQ-014 The block SHALL have port o_zero, output, 1 bit: o_result is all zeros.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-016 o_ready SHALL be 1 only in IDLE, and o_valid SHALL be 1 only in DONE.
REQ-017 Acceptance SHALL occur on an edge where i_valid=1 and o_ready=1.
REQ-018 On acceptance, the block SHALL latch i_A into the A register.
REQ-019 On acceptance, the block SHALL latch i_B into the B register as ~i_B when i_sub=1 and as i_B otherwise.
REQ-020 On acceptance, the block SHALL initialise the carry register to i_sub, clear the nibble counter k, and move to RUN.
REQ-021 In RUN, each cycle SHALL process nibble k, bits [4k+3:4k], with a combinational 4-bit carry-lookahead slice.
REQ-022 The slice SHALL compute P = a^b and G = a&b, form internal carries c1..c4 by the full lookahead equations from the carry register, and form sum bit j = P[j]^c[j].
REQ-023 Each RUN cycle SHALL write the 4 sum bits into o_result[4k+3:4k] and store c4 in the carry register.
REQ-024 On the final nibble (k = WIDTH/4-1), the block SHALL capture the carry into bit WIDTH-1 (c3 of that slice) for overflow detection.
REQ-025 After the final nibble the block SHALL move to DONE, so o_valid rises exactly WIDTH/4 cycles after the acceptance edge (8 for the default).
REQ-026 In DONE: o_carry SHALL equal the final c4.
REQ-027 In DONE: o_overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-028 In DONE: o_zero SHALL be 1 if and only if o_result is all zeros.
REQ-029 DONE SHALL hold all outputs stable until i_ready=1.
REQ-030 On the edge where o_valid=1 and i_ready=1, the block SHALL return to IDLE.
REQ-031 There SHALL be no back-to-back acceptance in that DONE cycle; the next operand can be accepted at the earliest one cycle after return to IDLE.
REQ-032 i_valid, i_A, i_B and i_sub SHALL be ignored outside IDLE; changes to them during RUN or DONE SHALL NOT affect the result.
REQ-033 o_result SHALL read as partially updated during RUN and is valid only while o_valid=1.
REQ-034 Arithmetic SHALL be modulo 2^WIDTH.
REQ-035 Subtract SHALL be computed as A + ~B + 1.
REQ-036 If i_valid is held at 1 continuously, the block SHALL process one operation per WIDTH/4+2 cycles when i_ready is tied to 1.

Reset
REQ-037 While i_rst=1 at an edge, the state SHALL go to IDLE, with o_ready=1 after the edge.
REQ-038 While i_rst=1 at an edge, o_valid, o_result, o_carry, o_overflow, the counter and the carry register SHALL all be cleared to 0.
REQ-039 While i_rst=1 at an edge, o_zero SHALL be 0.
REQ-040 Reset SHALL take priority over acceptance and over the output handshake.
REQ-041 Reset asserted mid-RUN or in DONE SHALL abort the operation with no later o_valid for it.

Verification
REQ-042 The bench SHALL cover: add A=0x0000000C, B=0x0000000A -> o_result=0x00000016, carry=0, overflow=0, zero=0, with o_valid exactly 8 cycles after acceptance.
REQ-043 The bench SHALL cover: add 0xFFFFFFFF + 0x00000001 -> result=0x00000000, carry=1, zero=1, overflow=0; and add 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow=1, carry=0.
REQ-044 The bench SHALL cover: sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, carry=1, overflow=1; and sub 5 - 7 -> 0xFFFFFFFE, carry=0, overflow=0.
REQ-045 The bench SHALL cover: i_ready held at 0 for 3 cycles in DONE -> outputs unchanged and o_ready=0; i_valid pulsed with new operands during RUN -> ignored, result unchanged.
REQ-046 The bench SHALL cover: i_rst asserted for 1 cycle at RUN cycle 4 -> next cycle o_ready=1, o_valid=0, all outputs 0; a following add 1+1 -> result 0x00000002.
REQ-047 The bench SHALL cover: a random sweep of 1000 add and subtract operations checked against a reference model, for the sum and all three flags.
